// File: rtl/word_serdes_reg.sv
// word_serdes_reg: byte-serial <-> word-parallel register.
// Assembles a BYTES-byte word from an 8-bit serial bus and streams a
// parallel-loaded word back out, one byte per shift_out command. Byte order
// (LSB-first or MSB-first) is latched at each word boundary.
//
// Command semantics: load, shift_in and shift_out are single-cycle strobes
// acting on the rising edge they are high for. At most one may be high per
// cycle. serial_out is valid whenever out_empty is low, and the consumer takes
// it on the same edge that sees shift_out high (shift_out acts as "ready").
// Any illegal command combination raises error combinationally and that
// cycle leaves all state untouched.
module word_serdes_reg #(
   parameter  int BYTES = 2,
   localparam int W     = 8 * BYTES,
   localparam int CW    = $clog2(BYTES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          shift_in,
   input  logic          shift_out,
   input  logic          msb_first,
   input  logic [7:0]    serial_in,
   input  logic [W-1:0]  prll_in,
   output logic [W-1:0]  prll_out,
   output logic [7:0]    serial_out,
   output logic [CW-1:0] in_count,
   output logic [CW-1:0] out_rem,
   output logic          word_valid,
   output logic          out_empty,
   output logic          error
);

   localparam logic [CW-1:0] BYTES_C = CW'(BYTES);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [W-1:0]  data;
   logic [CW-1:0] in_count_q;
   logic [CW-1:0] out_rem_q;
   logic          mode_q;

   logic          multi_cmd;
   logic          word_boundary;
   logic          mode_eff;
   logic [W-1:0]  shifted;
   int            pos;

   // Illegal-command detection and the byte order that applies to an incoming byte
   always_comb begin
      multi_cmd     = (load & shift_in) | (load & shift_out) | (shift_in & shift_out);
      error         = multi_cmd | (shift_out & (out_rem_q == '0));
      // A new word starts from an empty or a completed word; only then is msb_first honoured
      word_boundary = (in_count_q == '0) || (in_count_q == BYTES_C);
      mode_eff      = word_boundary ? msb_first : mode_q;
   end

   // State register: reset, then exactly one legal command or hold
   always_ff @(posedge clk) begin
      if (rst) begin
         data       <= '0;
         in_count_q <= '0;
         out_rem_q  <= '0;
         mode_q     <= 1'b0;
      end else if (!error) begin
         if (load) begin
            data       <= prll_in;
            out_rem_q  <= BYTES_C;
            in_count_q <= '0;
            mode_q     <= msb_first;
         end else if (shift_in) begin
            mode_q     <= mode_eff;
            if (mode_eff)
               data <= {data[W-9:0], serial_in};
            else
               data <= {serial_in, data[W-1:8]};
            in_count_q <= (in_count_q == BYTES_C) ? ONE_C : in_count_q + ONE_C;
            // Receiving abandons any transmission still in progress
            out_rem_q  <= '0;
         end else if (shift_out) begin
            // Transmission is non-destructive: only the remaining count moves
            out_rem_q  <= out_rem_q - ONE_C;
         end
      end
   end

   // Select the current outgoing byte from the held word
   always_comb begin
      pos        = 0;
      shifted    = '0;
      serial_out = 8'h00;
      if (out_rem_q != '0) begin
         // MSB-first sends byte BYTES-1-k, which equals out_rem-1; LSB-first sends byte k
         if (mode_q)
            pos = int'(out_rem_q) - 1;
         else
            pos = BYTES - int'(out_rem_q);
         shifted    = data >> (8 * pos);
         serial_out = shifted[7:0];
      end
   end

   // Status outputs
   always_comb begin
      prll_out   = data;
      in_count   = in_count_q;
      out_rem    = out_rem_q;
      word_valid = (in_count_q == BYTES_C);
      out_empty  = (out_rem_q == '0);
   end

endmodule

// File: doc/word_serdes_reg.md
# word_serdes_reg

Parametrised byte-serial ↔ word-parallel register: the generalised successor to the 16-bit byte shifter used on the CPU's 8-bit serial bus. It assembles a word of `BYTES` bytes from the serial bus and streams a parallel-loaded word back out one byte per command. Byte order is selectable per word, and word-complete/drained status is tracked in counters. It sits between the 8-bit bus interface and the register file, PC and immediate paths.

## Interface
- `BYTES`, default 2: bytes per word; legal range 2..8.
- `W`, default 8*BYTES: word width; derived, never overridden.
- `CW`, default $clog2(BYTES+1): counter width; derived.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  capture `prll_in` for serial output.
- `shift_in`  in  1  accept `serial_in` as the next byte of the incoming word.
- `shift_out`  in  1  advance to the next output byte.
- `msb_first`  in  1  byte-order mode: 0 = least-significant byte first, 1 = most-significant byte first; sampled per word.
- `serial_in`  in  8  incoming byte.
- `prll_in`  in  W  word to transmit.
- `prll_out`  out  W  data register.
- `serial_out`  out  8  current output byte, combinational.
- `in_count`  out  CW  bytes received in the current word.
- `out_rem`  out  CW  bytes still to transmit.
- `word_valid`  out  1  `in_count == BYTES`.
- `out_empty`  out  1  `out_rem == 0`.
- `error`  out  1  combinational illegal-command flag.

## Operation
- State: `data[W-1:0]`, `in_count`, `out_rem`, `mode_q`. `prll_out = data`.
- `error` is high when either of these holds:
  - more than one of `load`/`shift_in`/`shift_out` is high;
  - `shift_out` is high while `out_rem == 0`.
- A cycle with `error` high changes no state.
- `load` (sole command):
  - `data <= prll_in`, `out_rem <= BYTES`, `in_count <= 0`, `mode_q <= msb_first`.
- `shift_in` (sole command):
  - If `in_count == 0` or `in_count == BYTES`, `mode_q <= msb_first` and the current `msb_first` applies to this byte. Otherwise `mode_q` is used.
  - LSB-first: `data <= {serial_in, data[W-1:8]}`. After BYTES shifts, the first byte sits in `[7:0]`.
  - MSB-first: `data <= {data[W-9:0], serial_in}`. After BYTES shifts, the first byte sits in `[W-1:W-8]`.
  - `in_count <= (in_count == BYTES) ? 1 : in_count + 1`. A new word wraps over a completed one.
  - `out_rem <= 0`, which abandons any pending transmission.
- `shift_out` (sole command, `out_rem > 0`):
  - `out_rem <= out_rem - 1`.
  - `data` is unchanged, so transmission is non-destructive.
- No command: all state holds.
- `serial_out`:
  - Let k = `BYTES - out_rem`, the number of bytes already sent.
  - LSB-first (`mode_q == 0`): byte k of `data`.
  - MSB-first (`mode_q == 1`): byte `BYTES-1-k` of `data`.
  - When `out_rem == 0`: 8'h00.
- Changing `msb_first` in the middle of a word has no effect until the next word boundary.

## Timing
- Reset values: `data`=0, `in_count`=0, `out_rem`=0, `mode_q`=0. So `prll_out`=0, `serial_out`=0, `word_valid`=0, `out_empty`=1, `error`=0 with no commands asserted.
- `rst` has priority over every command. Reset in the middle of a word discards all progress.
- Latency, all same-cycle updates:
  - `load` → `prll_out`, `out_rem` and the first `serial_out` byte valid in the next cycle.
  - Final `shift_in` → `word_valid` high in the next cycle. It stays high until the next `shift_in` or `load`.
  - `serial_out` for byte k is stable throughout the cycle in which `shift_out` is asserted. The consumer samples it on the same edge that asserts `shift_out`.
- `error` and `serial_out` are purely combinational from inputs and state; they have no registered delay.
- Back-to-back `shift_out` every cycle drains BYTES bytes in BYTES cycles. The next `shift_out` flags `error`.
- Back-to-back `shift_in` every cycle assembles one word per BYTES cycles. The cycle after `word_valid`, a `shift_in` starts the next word.

## Test plan
- Reset, BYTES=2: assert `rst` one cycle with all commands low → `prll_out`=0, `in_count`=0, `out_rem`=0, `out_empty`=1, `word_valid`=0, `serial_out`=0, `error`=0.
- LSB-first assemble, BYTES=2: `shift_in` 8'h34 then 8'h12 with `msb_first`=0 → `prll_out`=16'h1234, `word_valid`=1 after the second edge; a third `shift_in` 8'hAA → `in_count`=1, `word_valid`=0.
- MSB-first transmit, BYTES=4: `load` 32'hDEADBEEF with `msb_first`=1, then 4× `shift_out` → `serial_out` sequence DE, AD, BE, EF. A 5th `shift_out` → `error`=1, `out_rem` stays 0, `serial_out`=00.
- Mode latch: start an LSB-first word in BYTES=2 with `shift_in` 8'h01, toggle `msb_first`=1, then `shift_in` 8'h02 → `prll_out`=16'h0201 (mode unchanged mid-word).
- Conflict: `load`=1 and `shift_in`=1 in the same cycle after loading 16'h5A5A → `error`=1 and `prll_out`, `in_count`, `out_rem` all unchanged. `shift_in` during a pending transmit (`out_rem`=1) → `out_rem`=0.
- Reset mid-transmit, BYTES=2: after `load` 16'hC3F0 and one `shift_out`, assert `rst` → `out_rem`=0 and `prll_out`=0 in the next cycle, and `shift_out` afterwards flags `error`.
